// File: rtl/hamming_pkg.sv
// Shared widths, FSM state type and parity masks for the Hamming serial transmitter.
// Each mask selects the data bits that feed one parity bit of the 21-bit codeword.
package hamming_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned PAR_W      = 5;
  localparam int unsigned CODE_W     = 21;
  localparam int unsigned FRAME_BITS = 23;

  localparam logic [DATA_W-1:0] P0_MASK = 16'hAD5B;
  localparam logic [DATA_W-1:0] P1_MASK = 16'h366D;
  localparam logic [DATA_W-1:0] P2_MASK = 16'hC78E;
  localparam logic [DATA_W-1:0] P3_MASK = 16'h07F0;
  localparam logic [DATA_W-1:0] P4_MASK = 16'hF800;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

endpackage

// File: rtl/hamming_encoder16.sv
// Combinational encoder that appends five parity bits to a 16-bit word.
// Codeword layout is {data, p0, p1, p2, p3, p4}, so p4 lands in bit 0.
module hamming_encoder16
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  logic [PAR_W-1:0] par;

  assign par  = {^(data & P0_MASK), ^(data & P1_MASK), ^(data & P2_MASK),
                 ^(data & P3_MASK), ^(data & P4_MASK)};
  assign code = {data, par};

endmodule

// File: rtl/hamming_tx_arbiter.sv
// Two-requester round-robin arbiter that serializes each accepted word as a
// framed Hamming codeword: start bit, 21 code bits MSB first, stop bit.
module hamming_tx_arbiter
  import hamming_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              ser_out,
  output logic              frame_active,
  output logic              grant_id,
  output logic              frame_done
);

  localparam logic [7:0] CntLast = 8'(BIT_CYCLES - 1);
  localparam logic [4:0] BitLast = 5'(CODE_W - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              ser_q, ser_d;
  logic              active_q;
  logic [CODE_W-1:0] code;
  logic              bit_end;
  logic              accept;

  hamming_encoder16 u_enc (
    .data (data_q),
    .code (code)
  );

  assign bit_end = (cnt_q == CntLast);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_q);
      req1_ready = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign accept = req0_ready | req1_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    grant_d    = grant_q;
    last_d     = last_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          cnt_d   = 8'd0;
          data_d  = req1_ready ? req1_data : req0_data;
          grant_d = req1_ready;
          last_d  = req1_ready;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (bit_q == BitLast) begin
            state_d = STOP;
            bit_d   = 5'd0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d    = IDLE;
          cnt_d      = 8'd0;
          frame_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is registered from next-state values so it tracks the state with no extra lag.
  always_comb begin
    ser_d = 1'b1;
    unique case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = code[BitLast - bit_d];
      default: ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 5'd0;
      data_q   <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      ser_q    <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      ser_q    <= ser_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign ser_out      = ser_q;
  assign frame_active = active_q;
  assign grant_id     = grant_q;

endmodule

// File: doc/hamming_tx_arbiter.md
HAMMING_TX_ARBITER -- requirements
Module: hamming_tx_arbiter

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4: clock cycles per serial bit time; legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has a 16-bit message word.
REQ-005 SHALL have port req0_data  input  16  requester 0 message word.
REQ-006 SHALL have port req0_ready  output  1  requester 0 word accepted this cycle when valid is also high.
REQ-007 SHALL have ports req1_valid, req1_data, req1_ready, identical to the requester 0 ports, for requester 1.
REQ-008 SHALL have port ser_out  output  1  serial line; idles high.
REQ-009 SHALL have port frame_active  output  1  high for every cycle of a frame (start bit through stop bit).
REQ-010 SHALL have port grant_id  output  1  requester that owns the current or last frame.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 In IDLE, SHALL assert ready combinationally to exactly one requester: the only valid one; or, when both are valid, the one not granted last (round-robin); no ready when neither is valid.
REQ-014 A transfer (valid and ready both high in IDLE) SHALL capture the data word and update grant_id and last_grant, then enter START on the next edge.
REQ-015 Outside IDLE, both ready outputs SHALL be low; requesters hold valid and data until accepted.
REQ-016 Codeword SHALL be 21 bits: {data[15:0], p0, p1, p2, p3, p4}, where bit 20 = data[15] and bit 0 = p4.
REQ-017 Parity: p0 = XOR of data bits 0,1,3,4,6,8,10,11,13,15; p1 = XOR of bits 0,2,3,5,6,9,10,12,13; p2 = XOR of bits 1,2,3,7,8,9,10,14,15; p3 = XOR of bits 4..10; p4 = XOR of bits 11..15.
REQ-018 Frame format SHALL be: start bit 0, then codeword bits 20 down to 0 (MSB first), then stop bit 1; each bit held exactly BIT_CYCLES cycles; 23*BIT_CYCLES cycles per frame.
REQ-019 Transitions SHALL be: START to DATA after BIT_CYCLES cycles; DATA to STOP after 21 bit times; STOP to IDLE after BIT_CYCLES cycles.
REQ-020 Bit timing SHALL use a cycle counter (0..BIT_CYCLES-1) and a bit index (0..20); the counter wraps to 0 at each bit boundary.
REQ-021 ser_out and frame_active SHALL be registered; the start bit SHALL appear on the cycle after acceptance (latency 1).
REQ-022 frame_done SHALL pulse in the final STOP cycle; the next transfer SHALL be possible in the following cycle, so the back-to-back period is 23*BIT_CYCLES+1 cycles.
REQ-023 Data captured for a frame SHALL be immune to input changes until the frame ends.

Reset
REQ-024 While rst is high, SHALL force: state IDLE; ser_out 1; frame_active 0; frame_done 0; grant_id 0; counters 0; last_grant 1 (requester 0 wins the first tie).
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (ser_out 1 asynchronously); the aborted word is lost and is not re-sent.

Structure
REQ-026 Package hamming_pkg SHALL hold CODE_W=21, DATA_W=16, PAR_W=5, FRAME_BITS=23, the FSM state enum, and the five parity masks.
REQ-027 Parity generation SHALL be one sub-module instance, hamming_encoder16 (16-bit data in, 21-bit codeword out, combinational), fed from the captured data register.

Verification (BIT_CYCLES=1 unless stated)
REQ-028 req0 data 16'h0000 -> ser_out sequence 0, 21x0, 1; frame_done at cycle 23 after acceptance.
REQ-029 req1 data 16'hFFFF -> codeword 21'h1FFFEF serialized MSB first; grant_id=1.
REQ-030 req0 data 16'h0001 -> codeword 21'h000038; with BIT_CYCLES=4, each bit lasts 4 cycles and the frame lasts 92 cycles.
REQ-031 both valid at reset release, held -> req0 frame then req1 frame, back to back, 24 cycles apart; with both still valid, grants alternate.
REQ-032 rst pulsed in DATA bit 10 -> ser_out=1 and frame_active=0 at once; after release, IDLE and the pending request is accepted normally.
